adpll_loop_ctrl: RTL and testbench

- Digital loop controller for the ADPLL.
- Consumes the phase-frequency detector's up/down pulses and sequences acquisition as IDLE -> COARSE (binary search) -> FINE (PI filter) -> LOCKED.
- Drives the DCO control word and lock indication.
- Sits between the phase detector and the DCO; single system clock domain.

---
 rtl/adpll_loop_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_adpll_loop_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: binary-search coarse acquisition, PI fine tracking and lock detection.
// Optional LOCKED-state hold input is enabled by defining ADPLL_LOOP_CTRL_HOLD_EN.
module adpll_loop_ctrl #(
    parameter int CW       = 10,
    parameter int WIN      = 8,
    parameter int KP_SH    = 2,
    parameter int KI_SH    = 5,
    parameter int ACC_W    = 16,
    parameter int TOL      = 1,
    parameter int LOSS_TOL = 4,
    parameter int LOCK_CNT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          up,
    input  logic          down,
`ifdef ADPLL_LOOP_CTRL_HOLD_EN
    input  logic          hold,
`endif
    output logic [CW-1:0] dco_word,
    output logic          upd,
    output logic          locked,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COARSE = 2'd1,
        ST_FINE   = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;

    localparam int WIN_W = $clog2(WIN);
    localparam int ERR_W = WIN_W + 2;
    localparam int LCK_W = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0]          DCO_MID   = CW'(1) << (CW - 1);
    localparam logic [CW-1:0]          DCO_MAX   = '1;
    localparam logic [CW-1:0]          STEP0     = CW'(1) << (CW - 2);
    localparam logic [WIN_W-1:0]       WIN_LAST  = WIN_W'(WIN - 1);
    localparam logic [LCK_W-1:0]       LOCK_LAST = LCK_W'(LOCK_CNT - 1);
    localparam logic [ERR_W-1:0]       TOL_U     = ERR_W'(TOL);
    localparam logic [ERR_W-1:0]       LOSS_U    = ERR_W'(LOSS_TOL);
    localparam logic signed [ACC_W+1:0] INTEG_MAX = (ACC_W + 2)'(((1 << CW) - 1) << KI_SH);
    localparam logic signed [ACC_W+1:0] WORD_MAX  = (ACC_W + 2)'((1 << CW) - 1);

    state_e                   state_q;
    logic [CW-1:0]            dco_word_q;
    logic [CW-1:0]            step_q;
    logic                     upd_q;
    logic                     locked_q;
    logic [WIN_W-1:0]         win_cnt_q;
    logic signed [ERR_W-1:0]  err_q;
    logic signed [ACC_W-1:0]  integ_q;
    logic [LCK_W-1:0]         lock_cnt_q;
    logic                     up_meta_q;
    logic                     up_s_q;
    logic                     down_meta_q;
    logic                     down_s_q;

    logic                     hold_act;
    logic                     win_end;
    logic                     in_tol;
    logic                     out_of_lock;
    logic signed [ERR_W-1:0]  err_d;
    logic [ERR_W-1:0]         err_abs;
    logic signed [CW+1:0]     coarse_sum;
    logic [CW-1:0]            coarse_word_d;
    logic signed [ACC_W+1:0]  integ_sum;
    logic signed [ACC_W-1:0]  integ_d;
    logic signed [ACC_W+1:0]  fine_sum;
    logic [CW-1:0]            fine_word_d;

`ifdef ADPLL_LOOP_CTRL_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    assign win_end = (win_cnt_q == WIN_LAST);

    always_comb begin
        // Window error including the current cycle's synchronized detector sample.
        err_d = err_q;
        if (up_s_q && !down_s_q) begin
            err_d = err_q + ERR_W'(1);
        end else if (down_s_q && !up_s_q) begin
            err_d = err_q - ERR_W'(1);
        end
        err_abs     = err_d[ERR_W-1] ? $unsigned(-err_d) : $unsigned(err_d);
        in_tol      = (err_abs <= TOL_U);
        out_of_lock = (err_abs > LOSS_U);

        coarse_sum = $signed({2'b00, dco_word_q});
        if (err_d[ERR_W-1]) begin
            coarse_sum = coarse_sum - $signed({2'b00, step_q});
        end else if (err_d != '0) begin
            coarse_sum = coarse_sum + $signed({2'b00, step_q});
        end
        if (coarse_sum[CW+1]) begin
            coarse_word_d = '0;
        end else if (coarse_sum > $signed({2'b00, DCO_MAX})) begin
            coarse_word_d = DCO_MAX;
        end else begin
            coarse_word_d = coarse_sum[CW-1:0];
        end

        // Anti-windup: the integrator never leaves the representable DCO range.
        integ_sum = (ACC_W + 2)'(integ_q) + (ACC_W + 2)'(err_d);
        if (integ_sum[ACC_W+1]) begin
            integ_d = '0;
        end else if (integ_sum > INTEG_MAX) begin
            integ_d = INTEG_MAX[ACC_W-1:0];
        end else begin
            integ_d = integ_sum[ACC_W-1:0];
        end

        fine_sum = ((ACC_W + 2)'(integ_d) >>> KI_SH) + (ACC_W + 2)'(err_d >>> KP_SH);
        if (fine_sum[ACC_W+1]) begin
            fine_word_d = '0;
        end else if (fine_sum > WORD_MAX) begin
            fine_word_d = DCO_MAX;
        end else begin
            fine_word_d = fine_sum[CW-1:0];
        end
    end

    // NOTE: every register here uses <= so all branches see the pre-edge values of state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            dco_word_q  <= DCO_MID;
            step_q      <= '0;
            upd_q       <= 1'b0;
            locked_q    <= 1'b0;
            win_cnt_q   <= '0;
            err_q       <= '0;
            integ_q     <= '0;
            lock_cnt_q  <= '0;
            up_meta_q   <= 1'b0;
            up_s_q      <= 1'b0;
            down_meta_q <= 1'b0;
            down_s_q    <= 1'b0;
        end else begin
            up_meta_q   <= up;
            up_s_q      <= up_meta_q;
            down_meta_q <= down;
            down_s_q    <= down_meta_q;
            upd_q       <= 1'b0;

            if (!enable) begin
                state_q    <= ST_IDLE;
                dco_word_q <= DCO_MID;
                locked_q   <= 1'b0;
                win_cnt_q  <= '0;
                err_q      <= '0;
            end else if (state_q == ST_IDLE) begin
                state_q    <= ST_COARSE;
                step_q     <= STEP0;
                dco_word_q <= DCO_MID;
                locked_q   <= 1'b0;
                win_cnt_q  <= '0;
                err_q      <= '0;
            end else if (!win_end) begin
                win_cnt_q <= win_cnt_q + WIN_W'(1);
                err_q     <= err_d;
            end else begin
                win_cnt_q <= '0;
                err_q     <= '0;
                case (state_q)
                    ST_COARSE: begin
                        dco_word_q <= coarse_word_d;
                        upd_q      <= 1'b1;
                        step_q     <= step_q >> 1;
                        if (step_q == CW'(1)) begin
                            state_q    <= ST_FINE;
                            integ_q    <= ACC_W'(coarse_word_d) << KI_SH;
                            lock_cnt_q <= '0;
                        end
                    end
                    ST_FINE: begin
                        dco_word_q <= fine_word_d;
                        integ_q    <= integ_d;
                        upd_q      <= 1'b1;
                        if (in_tol) begin
                            lock_cnt_q <= lock_cnt_q + LCK_W'(1);
                            if (lock_cnt_q == LOCK_LAST) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            lock_cnt_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!hold_act) begin
                            dco_word_q <= fine_word_d;
                            integ_q    <= integ_d;
                            upd_q      <= 1'b1;
                            if (out_of_lock) begin
                                state_q    <= ST_FINE;
                                locked_q   <= 1'b0;
                                lock_cnt_q <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dco_word = dco_word_q;
    assign upd      = upd_q;
    assign locked   = locked_q;
    assign state    = state_q;

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Bench for adpll_loop_ctrl: directed acquisition/lock/abort steps plus biased random
// detector traffic, all compared every cycle against a behavioural reference model.
module tb_adpll_loop_ctrl;

    localparam int CW       = 10;
    localparam int WIN      = 8;
    localparam int KP_SH    = 2;
    localparam int KI_SH    = 5;
    localparam int TOL      = 1;
    localparam int LOSS_TOL = 4;
    localparam int LOCK_CNT = 64;
    localparam int WORD_MAX  = (1 << CW) - 1;
    localparam int MID       = 1 << (CW - 1);
    localparam int STEP0     = 1 << (CW - 2);
    localparam int INTEG_MAX = WORD_MAX * (1 << KI_SH);

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          enable = 1'b0;
    logic          up     = 1'b0;
    logic          down   = 1'b0;
    logic          hold   = 1'b0;
    logic [CW-1:0] dco_word;
    logic          upd;
    logic          locked;
    logic [1:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (plain integers, state numbers as on the state port).
    int m_state, m_dco, m_upd, m_locked, m_win, m_err, m_step, m_integ, m_lock;
    bit m_up_dl[$];
    bit m_dn_dl[$];

    adpll_loop_ctrl #(
        .CW(CW), .WIN(WIN), .KP_SH(KP_SH), .KI_SH(KI_SH), .ACC_W(16),
        .TOL(TOL), .LOSS_TOL(LOSS_TOL), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .up      (up),
        .down    (down),
`ifdef ADPLL_LOOP_CTRL_HOLD_EN
        .hold    (hold),
`endif
        .dco_word(dco_word),
        .upd     (upd),
        .locked  (locked),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int floor_div(input int v, input int d);
        return (v >= 0) ? v / d : -((-v + d - 1) / d);
    endfunction

    task automatic model_reset();
        m_state = 0; m_dco = MID; m_upd = 0; m_locked = 0;
        m_win = 0; m_err = 0; m_step = 0; m_integ = 0; m_lock = 0;
        m_up_dl = '{1'b0, 1'b0};
        m_dn_dl = '{1'b0, 1'b0};
    endtask

    task automatic model_window_end(input int e);
        int mag;
        mag = (e < 0) ? -e : e;
        if (m_state == 1) begin
            m_dco = clamp(m_dco + ((e > 0) ? m_step : (e < 0) ? -m_step : 0), 0, WORD_MAX);
            m_upd = 1;
            if (m_step == 1) begin
                m_state = 2;
                m_integ = m_dco * (1 << KI_SH);
                m_lock  = 0;
            end
            m_step = m_step / 2;
        end else if (!(m_state == 3 && hold)) begin
            m_integ = clamp(m_integ + e, 0, INTEG_MAX);
            m_dco   = clamp(m_integ / (1 << KI_SH) + floor_div(e, 1 << KP_SH), 0, WORD_MAX);
            m_upd   = 1;
            if (m_state == 2) begin
                m_lock = (mag <= TOL) ? m_lock + 1 : 0;
                if (m_lock == LOCK_CNT) begin
                    m_state  = 3;
                    m_locked = 1;
                end
            end else if (mag > LOSS_TOL) begin
                m_state  = 2;
                m_locked = 0;
                m_lock   = 0;
            end
        end
    endtask

    // One rising edge of the model; the detector inputs reach the loop two edges late.
    task automatic model_step();
        bit us, ds;
        int e;
        m_up_dl.push_back(up);
        m_dn_dl.push_back(down);
        us = m_up_dl.pop_front();
        ds = m_dn_dl.pop_front();
        m_upd = 0;
        if (!enable) begin
            m_state = 0; m_dco = MID; m_locked = 0; m_win = 0; m_err = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_step = STEP0; m_win = 0; m_err = 0;
        end else begin
            e = m_err + ((us && !ds) ? 1 : 0) - ((ds && !us) ? 1 : 0);
            if (m_win == WIN - 1) begin
                m_win = 0;
                m_err = 0;
                model_window_end(e);
            end else begin
                m_win++;
                m_err = e;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("dco_word", dco_word, m_dco);
        check("upd", upd, m_upd);
        check("locked", locked, m_locked);
        check("state", state, m_state);
    endtask

    task automatic wait_upd(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!upd && n < budget);
        if (!upd) check({tag, "_timeout"}, upd, 1);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        check({tag, "_dco"}, dco_word, MID);
        check({tag, "_upd"}, upd, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_state"}, state, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_word;
        int n;
        int bu, bd;

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_dco", dco_word, MID);
        check("reset_upd", upd, 0);
        check("reset_locked", locked, 0);
        check("reset_state", state, 0);
        rst = 1'b1;
        repeat (3) tick();

        // Coarse search upward; release up just before the final step.
        enable = 1'b1;
        up     = 1'b1;
        exp_word = MID;
        for (int i = 0; i < CW - 1; i++) begin
            wait_upd(WIN + 4, "coarse_up_upd");
            exp_word += STEP0 >> i;
            check("coarse_up_dco", dco_word, exp_word);
            if (i == CW - 3) up = 1'b0;
        end
        check("coarse_up_state", state, 2);

        // Quiet detector: lock after exactly LOCK_CNT fine windows.
        n = 0;
        while (!locked && n < LOCK_CNT + 8) begin
            wait_upd(WIN + 2, "fine_upd");
            check("fine_dco_const", dco_word, WORD_MAX);
            n++;
        end
        check("lock_windows", n, LOCK_CNT);
        check("lock_state", state, 3);

        // Large error drops lock; DCO word pinned at full scale.
        up = 1'b1;
        wait_upd(WIN + 2, "loss_upd");
        check("loss_locked", locked, 0);
        check("loss_state", state, 2);
        for (int i = 0; i < 16; i++) begin
            wait_upd(WIN + 2, "sat_upd");
            check("sat_dco", dco_word, WORD_MAX);
        end

        // Restart and search downward.
        enable = 1'b0;
        up     = 1'b0;
        tick();
        check("idle_state", state, 0);
        check("idle_dco", dco_word, MID);
        down   = 1'b1;
        enable = 1'b1;
        exp_word = MID;
        for (int i = 0; i < CW - 1; i++) begin
            wait_upd(WIN + 4, "coarse_dn_upd");
            exp_word -= STEP0 >> i;
            check("coarse_dn_dco", dco_word, exp_word);
        end
        check("coarse_dn_state", state, 2);

        // Abort during the 4th coarse window, then restart from the top step.
        enable = 1'b0;
        down   = 1'b0;
        tick();
        up     = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) wait_upd(WIN + 4, "abort_pre_upd");
        repeat (3) tick();
        enable = 1'b0;
        tick();
        check("abort_state", state, 0);
        check("abort_dco", dco_word, MID);
        check("abort_upd", upd, 0);
        enable = 1'b1;
        wait_upd(WIN + 4, "restart_upd");
        check("restart_dco", dco_word, MID + STEP0);
        repeat (5) tick();
        async_reset("areset_coarse");

`ifdef ADPLL_LOOP_CTRL_HOLD_EN
        // Lock at mid-scale with a silent detector, then hold through a big error.
        up = 1'b0;
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        n = 0;
        while (!locked && n < CW - 1 + LOCK_CNT + 8) begin
            wait_upd(WIN + 4, "relock_upd");
            n++;
        end
        check("relock_locked", locked, 1);
        hold = 1'b1;
        up   = 1'b1;
        for (int i = 0; i < 5 * WIN; i++) begin
            tick();
            check("hold_upd", upd, 0);
            check("hold_dco", dco_word, MID);
            check("hold_locked", locked, 1);
        end
        hold = 1'b0;
        wait_upd(WIN + 2, "unhold_upd");
        check("unhold_locked", locked, 0);
        up = 1'b0;
`endif

        // Biased random detector traffic with occasional enable drops and one reset.
        enable = 1'b1;
        bu = 0;
        bd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 256 == 0) begin
                bu = $urandom_range(8);
                bd = $urandom_range(8);
            end
            up     = ($urandom_range(15) < bu);
            down   = ($urandom_range(15) < bd);
            enable = ($urandom_range(299) != 0);
            if (i == 1500) async_reset("areset_random");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
